// File: rtl/fibo_engine_if.sv
// ============================================================================
//  Module      : fibo_engine_if
//  Description : Request/result bundle for the fibo_engine compute block.
//                master = requester side, slave = engine side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fibo_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic             start;
  logic [CNT_W-1:0] n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fib;
  logic             zero_flag;
  logic             overflow;

  modport master (
    output start, n,
    input  busy, done, fib, zero_flag, overflow
  );

  modport slave (
    input  start, n,
    output busy, done, fib, zero_flag, overflow
  );

endinterface

`default_nettype wire

// File: rtl/fibo_engine.sv
// ============================================================================
//  Module      : fibo_engine
//  Description : Self-sequenced Fibonacci calculator. Captures term index n
//                on an accepted start and produces F(n) with a one-cycle done
//                pulse, a zero flag and an overflow flag.
//                Optional macro FIBO_SAT_EN: saturate the result to all-ones
//                once F(n) no longer fits in WIDTH bits (default: wrap).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fibo_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fibo_engine_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // a = F(i), b = F(i+1); ov_a / ov_b say whether those terms exceeded WIDTH
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_k;
  logic             r_ov_a;
  logic             r_ov_b;

  logic [WIDTH-1:0] r_fib;
  logic             r_zero;
  logic             r_overflow;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_k_zero;
  logic [WIDTH:0]   w_sum_ext;
  logic             w_carry;
  logic [WIDTH-1:0] w_b_next;

  assign w_k_zero  = (r_k == '0);
  assign w_sum_ext = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry   = w_sum_ext[WIDTH];

`ifdef FIBO_SAT_EN
  // Once any term has overflowed, every later term is pinned to all-ones,
  // so the reported F(n) is all-ones exactly when overflow is reported.
  assign w_b_next = (w_carry | r_ov_a | r_ov_b) ? '1 : w_sum_ext[WIDTH-1:0];
`else
  assign w_b_next = w_sum_ext[WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_k_zero) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Iteration registers and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_k        <= '0;
      r_ov_a     <= 1'b0;
      r_ov_b     <= 1'b0;
      r_fib      <= '0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_a    <= '0;
        r_b    <= {{(WIDTH-1){1'b0}}, 1'b1};
        r_k    <= bus.n;
        r_ov_a <= 1'b0;
        r_ov_b <= 1'b0;
      end
      if (w_step) begin
        r_a    <= r_b;
        r_b    <= w_b_next;
        r_ov_a <= r_ov_b;
        r_ov_b <= r_ov_a | r_ov_b | w_carry;
        r_k    <= r_k - CNT_W'(1);
      end
      // Only the overflow of a (= F(n)) is reported; b may have overflowed
      // on the last step without affecting the result.
      if (w_finish) begin
        r_fib      <= r_a;
        r_zero     <= (r_a == '0);
        r_overflow <= r_ov_a;
      end
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.fib       = r_fib;
  assign bus.zero_flag = r_zero;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fibo_engine.sv
// ============================================================================
//  Module      : tb_fibo_engine
//  Description : Self-checking bench for fibo_engine (WIDTH=8, CNT_W=8).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fibo_engine;

`ifdef FIBO_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fibo_engine_if #(.WIDTH(8), .CNT_W(8)) bus ();

  fibo_engine #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int fib_wrap;
    int fib_sat;
    bit zero;
    bit ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: exact Fibonacci value (capped far above 2^8) plus mod-256 value
  function automatic void model(input int nn, output int f, output bit z, output bit ov);
    longint ea, eb, et;
    int     ma, mb, mt;
    ea = 0; eb = 1; ma = 0; mb = 1;
    for (int i = 0; i < nn; i++) begin
      et = ea + eb;
      ea = eb;
      eb = (et > 64'd1000000) ? 64'd1000000 : et;
      mt = (ma + mb) % 256;
      ma = mb;
      mb = mt;
    end
    ov = (ea >= 256);
    f  = (SAT && ov) ? 255 : ma;
    z  = (f == 0);
  endfunction

  // Counts edges until done is seen; busy samples before done are tallied
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done === 1'b1) return;
      if (bus.busy === 1'b1) bcnt++;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout waited=%0d required<=%0d", cyc, 400);
  endtask

  task automatic do_run(input int nn, input int efib, input bit ez, input bit eov, input string tag);
    int cyc, bc, b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nn[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    b0 = (bus.busy === 1'b1) ? 1 : 0;
    wait_done(cyc, bc);
    check({tag, " latency"}, cyc, nn + 1);
    check({tag, " busy_cycles"}, bc + b0, nn + 1);
    check({tag, " fib"}, bus.fib, efib);
    check({tag, " zero_flag"}, bus.zero_flag, ez);
    check({tag, " overflow"}, bus.overflow, eov);
    @(posedge clk); #1;
    check({tag, " done_width"}, bus.done, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   cyc, bc, pulses, rn, ef;
    bit   ez, eov;

    checks = 0;
    errors = 0;

    vecs[0] = '{0,   0,   0, 1'b1, 1'b0};
    vecs[1] = '{1,   1,   1, 1'b0, 1'b0};
    vecs[2] = '{2,   1,   1, 1'b0, 1'b0};
    vecs[3] = '{7,  13,  13, 1'b0, 1'b0};
    vecs[4] = '{10, 55,  55, 1'b0, 1'b0};
    vecs[5] = '{12, 144, 144, 1'b0, 1'b0};
    vecs[6] = '{13, 233, 233, 1'b0, 1'b0};
    vecs[7] = '{14, 121, 255, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.n     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset fib", bus.fib, 0);
    check("reset zero_flag", bus.zero_flag, 1);
    check("reset overflow", bus.overflow, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].n, SAT ? vecs[i].fib_sat : vecs[i].fib_wrap,
             vecs[i].zero, vecs[i].ov, $sformatf("vec_n%0d", vecs[i].n));
    end

    // Start while busy is ignored; start in done cycle is accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 8'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.n     = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc, bc);
    check("midstart latency", cyc + 6, 21);
    check("midstart fib", bus.fib, SAT ? 255 : 109);
    check("midstart overflow", bus.overflow, 1);
    bus.start = 1'b1;
    bus.n     = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b done_width", bus.done, 0);
    check("b2b busy", bus.busy, 1);
    wait_done(cyc, bc);
    check("b2b latency", cyc, 4);
    check("b2b fib", bus.fib, 2);
    check("b2b zero_flag", bus.zero_flag, 0);
    check("b2b overflow", bus.overflow, 0);

    // Reset aborts a run
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 8'd50;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort fib", bus.fib, 0);
    check("abort zero_flag", bus.zero_flag, 1);
    check("abort overflow", bus.overflow, 0);
    pulses = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort no_done", pulses, 0);
    do_run(1, 1, 1'b0, 1'b0, "after_abort");

    // Largest index
    model(255, ef, ez, eov);
    do_run(255, ef, ez, eov, "n255");

    // Randomized runs against the reference model
    for (int i = 0; i < 20; i++) begin
      rn = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 255);
      model(rn, ef, ez, eov);
      do_run(rn, ef, ez, eov, $sformatf("rand%0d_n%0d", i, rn));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
